// File: rtl/adder_stim_gen.sv
// Packet stimulus source for adder energy characterization: emits PAYLOAD-flit packets
// of 2N-bit operand words over valid/ready, GAP idle cycles apart, NUM_PKT times per run.
module adder_stim_gen #(
   parameter int          N       = 21,
   parameter int          PAYLOAD = 20,
   parameter int          GAP     = 7,
   parameter int          NUM_PKT = 10,
   parameter int          STRIDE  = 1,
   parameter logic [31:0] SEED    = 32'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [N-1:0] input1_o,
   output logic [N-1:0] input2_o,
   output logic         busy,
   output logic         done,
   output logic [15:0]  flit_cnt,
   output logic [15:0]  pkt_cnt
);
   localparam int W   = 2 * N;
   localparam int KW  = $clog2(4 * N + 2);
   localparam int REP = (W + 31) / 32;

   localparam logic [KW-1:0] STRIDE_K  = KW'(STRIDE);
   localparam logic [KW-1:0] WRAP_K    = KW'(W + 1);
   localparam logic [15:0]   LAST_FLIT = 16'(PAYLOAD - 1);
   localparam logic [15:0]   LAST_PKT  = 16'(NUM_PKT - 1);
   localparam logic [15:0]   GAP_LOAD  = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
   localparam bit            HAS_GAP   = (GAP > 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      M_THERMO = 2'd0,
      M_LFSR   = 2'd1,
      M_TOGGLE = 2'd2,
      M_ZERO   = 2'd3
   } mode_t;

   // 32-bit Fibonacci LFSR, taps 32,22,2,1
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [W-1:0] lfsr_word(input logic [31:0] s);
      logic [REP*32-1:0] rep;
      rep = {REP{s}};
      return rep[W-1:0];
   endfunction

   function automatic logic [W-1:0] ones_lsb(input logic [KW-1:0] k);
      return ~({W{1'b1}} << k);
   endfunction

   function automatic logic [W-1:0] ones_msb(input logic [KW-1:0] k);
      return ~({W{1'b1}} >> k);
   endfunction

   function automatic logic [KW-1:0] k_advance(input logic [KW-1:0] k);
      logic [KW-1:0] sum;
      sum = k + STRIDE_K;
      return (sum >= WRAP_K) ? (sum - WRAP_K) : sum;
   endfunction

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [KW-1:0] k_q, k_d;
   logic          phase_q, phase_d;
   logic [W-1:0]  word_q, word_d;
   logic          valid_q, valid_d;
   logic [15:0]   flit_q, flit_d;
   logic [15:0]   pkt_q, pkt_d;
   logic [15:0]   gap_q, gap_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          start_s;
   logic          accept_s;
   logic          load_s;
   mode_t         gen_mode_s;
   logic [31:0]   gen_lfsr_s;
   logic [KW-1:0] gen_k_s;
   logic          gen_phase_s;
   logic [W-1:0]  nxt_word_s;
   logic [31:0]   nxt_lfsr_s;
   logic [KW-1:0] nxt_k_s;
   logic          nxt_phase_s;

   assign start_s  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign accept_s = valid_q & ready_i;

   // A starting run generates its first word from the fresh generator state
   always_comb begin
      if (start_s) begin
         gen_mode_s  = mode_t'(mode);
         gen_lfsr_s  = SEED;
         gen_k_s     = {KW{1'b0}};
         gen_phase_s = 1'b0;
      end else begin
         gen_mode_s  = mode_q;
         gen_lfsr_s  = lfsr_q;
         gen_k_s     = k_q;
         gen_phase_s = phase_q;
      end
   end

   always_comb begin
      nxt_word_s  = {W{1'b0}};
      nxt_lfsr_s  = gen_lfsr_s;
      nxt_k_s     = gen_k_s;
      nxt_phase_s = ~gen_phase_s;
      case (gen_mode_s)
         M_THERMO: begin
            if (!gen_phase_s) begin
               nxt_k_s    = k_advance(gen_k_s);
               nxt_word_s = ones_lsb(nxt_k_s);
            end else begin
               nxt_word_s = ones_msb(gen_k_s);
            end
         end
         M_LFSR: begin
            nxt_word_s = lfsr_word(gen_lfsr_s);
            nxt_lfsr_s = lfsr_step(gen_lfsr_s);
         end
         M_TOGGLE: begin
            nxt_word_s = gen_phase_s ? {W{1'b0}} : {W{1'b1}};
         end
         M_ZERO: begin
            nxt_word_s = {W{1'b0}};
         end
         default: begin
            nxt_word_s = {W{1'b0}};
         end
      endcase
   end

   // Last flit of a packet leaving SEND keeps the word, so gaps and DONE cost no toggle
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      lfsr_d  = lfsr_q;
      k_d     = k_q;
      phase_d = phase_q;
      word_d  = word_q;
      valid_d = valid_q;
      flit_d  = flit_q;
      pkt_d   = pkt_q;
      gap_d   = gap_q;
      load_s  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_s) begin
               state_d = S_SEND;
               mode_d  = mode_t'(mode);
               flit_d  = 16'd0;
               pkt_d   = 16'd0;
               gap_d   = 16'd0;
               valid_d = 1'b1;
               load_s  = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         S_SEND: begin
            if (accept_s) begin
               if (flit_q == LAST_FLIT) begin
                  flit_d = 16'd0;
                  pkt_d  = pkt_q + 16'd1;
                  if (pkt_q == LAST_PKT) begin
                     state_d = S_DONE;
                     valid_d = 1'b0;
                  end else if (HAS_GAP) begin
                     state_d = S_GAP;
                     gap_d   = GAP_LOAD;
                     valid_d = 1'b0;
                  end else begin
                     load_s = 1'b1;
                  end
               end else begin
                  flit_d = flit_q + 16'd1;
                  load_s = 1'b1;
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == 16'd0) begin
               state_d = S_SEND;
               valid_d = 1'b1;
               load_s  = 1'b1;
            end else begin
               gap_d = gap_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
      if (load_s) begin
         word_d  = nxt_word_s;
         lfsr_d  = nxt_lfsr_s;
         k_d     = nxt_k_s;
         phase_d = nxt_phase_s;
      end else begin
         word_d = word_q;
      end
      busy_d = (state_d == S_SEND) | (state_d == S_GAP);
      done_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= M_THERMO;
         lfsr_q  <= SEED;
         k_q     <= {KW{1'b0}};
         phase_q <= 1'b0;
         word_q  <= {W{1'b0}};
         valid_q <= 1'b0;
         flit_q  <= 16'd0;
         pkt_q   <= 16'd0;
         gap_q   <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         lfsr_q  <= lfsr_d;
         k_q     <= k_d;
         phase_q <= phase_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         flit_q  <= flit_d;
         pkt_q   <= pkt_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign valid_o  = valid_q;
   assign input1_o = word_q[N-1:0];
   assign input2_o = word_q[W-1:N];
   assign busy     = busy_q;
   assign done     = done_q;
   assign flit_cnt = flit_q;
   assign pkt_cnt  = pkt_q;

endmodule

// File: tb/tb_adder_stim_gen.sv
// Bench for adder_stim_gen: a word/schedule model scoreboards one N=4 instance every cycle;
// three more instances cover the toggle-with-gap, zero-gap and default-size runs directly.
module tb_adder_stim_gen;
   localparam int P   = 3;
   localparam int G   = 2;
   localparam int NP  = 8;
   localparam int TOT = P * NP;

   logic clk;
   logic rst;

   logic       start_m, ready_m, valid_m, busy_m, done_m;
   logic [1:0] mode_m;
   logic [3:0] in1_m, in2_m;
   logic [15:0] flit_m, pkt_m;

   logic       start_b, ready_b, valid_b, busy_b, done_b;
   logic [1:0] mode_b;
   logic [3:0] in1_b, in2_b;
   logic [15:0] flit_b, pkt_b;

   logic       start_c, ready_c, valid_c, busy_c, done_c;
   logic [1:0] mode_c;
   logic [3:0] in1_c, in2_c;
   logic [15:0] flit_c, pkt_c;

   logic        start_d, ready_d, valid_d, busy_d, done_d;
   logic [1:0]  mode_d;
   logic [20:0] in1_d, in2_d;
   logic [15:0] flit_d, pkt_d;

   int n_vec = 0;
   int n_err = 0;

   bit m_active = 1'b0;
   int m_acc    = 0;
   int m_gap    = 0;
   int m_mode   = 0;

   adder_stim_gen #(.N(4), .PAYLOAD(P), .GAP(G), .NUM_PKT(NP), .STRIDE(1)) u_main (
      .clk(clk), .rst(rst), .start(start_m), .mode(mode_m), .ready_i(ready_m),
      .valid_o(valid_m), .input1_o(in1_m), .input2_o(in2_m), .busy(busy_m),
      .done(done_m), .flit_cnt(flit_m), .pkt_cnt(pkt_m));

   adder_stim_gen #(.N(4), .PAYLOAD(3), .GAP(2), .NUM_PKT(2)) u_t2 (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .ready_i(ready_b),
      .valid_o(valid_b), .input1_o(in1_b), .input2_o(in2_b), .busy(busy_b),
      .done(done_b), .flit_cnt(flit_b), .pkt_cnt(pkt_b));

   adder_stim_gen #(.N(4), .PAYLOAD(2), .GAP(0), .NUM_PKT(3)) u_t5 (
      .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .ready_i(ready_c),
      .valid_o(valid_c), .input1_o(in1_c), .input2_o(in2_c), .busy(busy_c),
      .done(done_c), .flit_cnt(flit_c), .pkt_cnt(pkt_c));

   adder_stim_gen u_t6 (
      .clk(clk), .rst(rst), .start(start_d), .mode(mode_d), .ready_i(ready_d),
      .valid_o(valid_d), .input1_o(in1_d), .input2_o(in2_d), .busy(busy_d),
      .done(done_d), .flit_cnt(flit_d), .pkt_cnt(pkt_d));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Word at accept index j of a run for N=4 (8-bit word), straight from the mode rules
   function automatic logic [7:0] word_of(input int md, input int j);
      int k;
      logic [8:0] ones;
      logic [31:0] s;
      case (md)
         0: begin
            k = ((j / 2) + 1) % 9;
            ones = (9'd1 << k) - 9'd1;
            if (j % 2 == 0) return ones[7:0];
            else return ones[7:0] << (8 - k);
         end
         1: begin
            s = 32'hACE1;
            for (int i = 0; i < j; i++) s = (s << 1) | {31'd0, ^(s & 32'h80200003)};
            return s[7:0];
         end
         2: return (j % 2 == 0) ? 8'hFF : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   // Schedule model: accepts counted per run, GAP idle cycles after each non-final packet
   always @(posedge clk) begin
      if (rst) begin
         m_active <= 1'b0;
         m_acc    <= 0;
         m_gap    <= 0;
      end else if (!m_active || m_acc == TOT) begin
         if (start_m) begin
            m_active <= 1'b1;
            m_acc    <= 0;
            m_gap    <= 0;
            m_mode   <= int'(mode_m);
         end
      end else if (m_gap > 0) begin
         m_gap <= m_gap - 1;
      end else if (ready_m) begin
         m_acc <= m_acc + 1;
         if (((m_acc + 1) % P == 0) && (m_acc + 1 < TOT)) m_gap <= G;
      end
   end

   always @(negedge clk) begin
      logic       ev;
      logic [7:0] ew;
      if (rst) begin
         chk("rst_valid", valid_m, 0);
         chk("rst_word", {in2_m, in1_m}, 0);
         chk("rst_busy", busy_m, 0);
         chk("rst_done", done_m, 0);
         chk("rst_flit", flit_m, 0);
         chk("rst_pkt", pkt_m, 0);
      end else begin
         ev = m_active && (m_gap == 0) && (m_acc < TOT);
         if (!m_active) ew = 8'h00;
         else if (ev) ew = word_of(m_mode, m_acc);
         else ew = word_of(m_mode, m_acc - 1);
         chk("valid", valid_m, ev);
         chk("word", {in2_m, in1_m}, ew);
         chk("busy", busy_m, m_active && (m_acc < TOT));
         chk("done", done_m, m_active && (m_acc == TOT));
         chk("flit_cnt", flit_m, m_acc % P);
         chk("pkt_cnt", pkt_m, m_acc / P);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done_m(input int lim);
      int i;
      i = 0;
      while (!done_m && i < lim) begin
         tick(1);
         i++;
      end
      chk("main_done_timeout", done_m, 1);
   endtask

   logic [7:0] thermo_ref [19] = '{8'h01, 8'h80, 8'h03, 8'hC0, 8'h07, 8'hE0, 8'h0F, 8'hF0,
                                   8'h1F, 8'hF8, 8'h3F, 8'hFC, 8'h7F, 8'hFE, 8'hFF, 8'hFF,
                                   8'h00, 8'h00, 8'h01};
   logic [7:0] t2_w [9] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
   logic       t2_v [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      int cyc, acc, low;
      rst = 1'b1;
      start_m = 1'b0; mode_m = 2'd0; ready_m = 1'b0;
      start_b = 1'b0; mode_b = 2'd0; ready_b = 1'b0;
      start_c = 1'b0; mode_c = 2'd0; ready_c = 1'b0;
      start_d = 1'b0; mode_d = 2'd0; ready_d = 1'b0;

      for (int j = 0; j < 19; j++) chk("model_thermo", word_of(0, j), thermo_ref[j]);
      chk("model_lfsr0", word_of(1, 0), 8'hE1);
      chk("model_lfsr1", word_of(1, 1), 8'hC3);
      chk("model_lfsr2", word_of(1, 2), 8'h86);

      tick(3);
      rst = 1'b0;
      tick(1);

      // thermometer run with wrap, then toggle run restarted from DONE with backpressure
      mode_m = 2'd0; ready_m = 1'b1; start_m = 1'b1;
      tick(1);
      start_m = 1'b0;
      wait_done_m(200);
      tick(2);
      mode_m = 2'd2; start_m = 1'b1;
      tick(1);
      start_m = 1'b0;
      tick(2);
      ready_m = 1'b0;
      tick(5);
      ready_m = 1'b1;
      wait_done_m(200);

      // LFSR run interrupted by reset, then restarted from SEED
      mode_m = 2'd1; start_m = 1'b1;
      tick(1);
      start_m = 1'b0;
      tick(5);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      start_m = 1'b1;
      tick(1);
      start_m = 1'b0;
      wait_done_m(200);

      // zero mode with random backpressure and a stray start mid-run
      mode_m = 2'd3; start_m = 1'b1;
      tick(1);
      start_m = 1'b0;
      for (int i = 0; i < 200 && !done_m; i++) begin
         ready_m = 1'($urandom_range(0, 1));
         start_m = (i == 10);
         tick(1);
      end
      start_m = 1'b0;
      ready_m = 1'b1;
      wait_done_m(100);

      // toggle, PAYLOAD=3 GAP=2 NUM_PKT=2
      mode_b = 2'd2; ready_b = 1'b1; start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("t2_valid", valid_b, t2_v[i]);
         chk("t2_word", {in2_b, in1_b}, t2_w[i]);
         if (i == 8) begin
            chk("t2_done", done_b, 1);
            chk("t2_pkt", pkt_b, 2);
         end
         @(posedge clk);
         #1;
      end

      // GAP=0: six back-to-back accepts, DONE, restart clears pkt_cnt
      mode_c = 2'd2; ready_c = 1'b1; start_c = 1'b1;
      tick(1);
      start_c = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i < 6) begin
            chk("t5_valid", valid_c, 1);
            chk("t5_word", {in2_c, in1_c}, (i % 2 == 0) ? 8'hFF : 8'h00);
         end else begin
            chk("t5_valid_end", valid_c, 0);
            chk("t5_done", done_c, 1);
            chk("t5_pkt", pkt_c, 3);
         end
      end
      @(posedge clk);
      #1 start_c = 1'b1;
      tick(1);
      start_c = 1'b0;
      @(negedge clk);
      chk("t5_restart_valid", valid_c, 1);
      chk("t5_restart_pkt", pkt_c, 0);
      chk("t5_restart_done", done_c, 0);
      chk("t5_restart_word", {in2_c, in1_c}, 8'hFF);

      // default parameters, thermometer, always ready
      @(posedge clk);
      #1;
      mode_d = 2'd0; ready_d = 1'b1; start_d = 1'b1;
      tick(1);
      start_d = 1'b0;
      cyc = 0; acc = 0; low = 0;
      while (cyc < 400) begin
         @(negedge clk);
         if (done_d) break;
         if (valid_d) acc++;
         else low++;
         @(posedge clk);
         cyc++;
      end
      chk("t6_done_cycle", cyc, 263);
      chk("t6_accepts", acc, 200);
      chk("t6_gap_cycles", low, 63);
      chk("t6_pkt", pkt_d, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
